orbit_ctrl: RTL and testbench
=============================

ORBIT_CTRL -- requirements
Module: orbit_ctrl

Interface
REQ-001 Parameter CENTER_X, 320, orbit centre X in pixels.
REQ-002 Parameter CENTER_Y, 240, orbit centre Y in pixels.
REQ-003 Parameter RADIUS, 80, orbit radius in pixels, unsigned 8-bit.
REQ-004 Parameter BALL_SIZE, 4, constant ball half-size.
REQ-005 Clk  in  1  single system clock; all logic on its rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 frame_tick  in  1  one-Clk pulse per video frame.
REQ-008 keycode  in  8  current key; 0x04 = counter-clockwise, 0x07 = clockwise, other = none.
REQ-009 halt  in  1  high = freeze rotation (dead/paused); positions still recomputed.
REQ-010 RedX, RedY  out  10 each  red ball centre.
REQ-011 BlueX, BlueY  out  10 each  blue ball centre.
REQ-012 BallS  out  10  constant BALL_SIZE.
REQ-013 angle_index  out  6  red ball angle step, 0..59, 6 degrees per step.
REQ-014 pos_valid  out  1  one-cycle pulse when all four position outputs have updated.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 FSM states IDLE, STEP, RED_X, RED_Y, BLUE_X, BLUE_Y, DONE; each non-IDLE state lasts exactly one cycle, in that order, DONE -> IDLE.
REQ-017 IDLE -> STEP when frame_tick=1 or pending=1; pending clears on entering STEP.
REQ-018 frame_tick while busy sets pending; multiple ticks while busy merge into one.
REQ-019 STEP: if halt=0 and keycode=0x04, angle_index increments, 59 wraps to 0; if keycode=0x07, decrements, 0 wraps to 59; otherwise unchanged.
REQ-020 keycode and halt are sampled only in STEP.
REQ-021 Blue index = (angle_index + 30) mod 60.
REQ-022 Trig LUT: 60 entries, signed 10-bit, value = round(256*cos(6 deg*i)) and round(256*sin(6 deg*i)); entry 0 cos=256, entry 30 cos=-256, entries 15/45 sin=+256/-256.
REQ-023 One shared 8x10 signed multiplier; one product per computation state.
REQ-024 X = CENTER_X + (RADIUS*cos >>> 8); Y = CENTER_Y - (RADIUS*sin >>> 8); arithmetic shift (floor), 18-bit product, result truncated to 10 bits.
REQ-025 Computed values go to shadow registers; RedX/RedY/BlueX/BlueY update together at the DONE edge, never mid-sequence.
REQ-026 pos_valid=1 only in DONE; latency frame_tick (cycle T, IDLE) -> pos_valid at T+6.
REQ-027 Sequence begun is always completed; halt/keycode changes mid-sequence have no effect.

Reset
REQ-028 Reset dominates all inputs; next state IDLE, pending=0, angle_index=0, pos_valid=0, busy=0.
REQ-029 Reset outputs: RedX=400, RedY=240, BlueX=240, BlueY=240 (derived from parameters), BallS=BALL_SIZE.
REQ-030 Reset mid-sequence aborts it; no pos_valid for the aborted sequence.

Structure
REQ-031 Package orbit_pkg holds state enum, ANGLE_STEPS=60, HALF_TURN=30, KEY_CCW=8'h04, KEY_CW=8'h07, LUT width 10, LUT fraction 8.
REQ-032 Sub-module orbit_trig_lut: combinational ROM, 6-bit index in, signed 10-bit cos and sin out; indices 60..63 return 0.
REQ-033 No real-typed signals; all arithmetic in synthesizable signed fixed point.

Verification
REQ-034 Reset, then frame_tick, keycode=0x00 -> pos_valid 6 cycles later, index 0, Red (400,240), Blue (240,240).
REQ-035 From index 0, one tick with keycode=0x07 -> index 59; with 0x04 from 59 -> index 0 (both wraps).
REQ-036 Five ticks keycode=0x04 -> index 5, Red (389,200), Blue (250,280).
REQ-037 halt=1, keycode=0x04, tick -> index unchanged, pos_valid still pulses, outputs unchanged.
REQ-038 Tick, plus two more ticks during busy -> exactly two pos_valid pulses; second at 7 cycles after first.
REQ-039 Reset asserted in RED_Y -> next cycle IDLE, reset positions, no pos_valid.

Source files
------------

// File: rtl/orbit_pkg.sv
// ---------------------------------------------------------------------------
// orbit_pkg
// Shared definitions for the orbiting-ball controller: the sequencer state
// type, angle and key constants, the fixed-point format of the trig table and
// the helper functions that generate the table entries.
// Ports: none (package).
// ---------------------------------------------------------------------------
package orbit_pkg;

  // Sequencer states, one computation state per output coordinate
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP,
    ST_RED_X,
    ST_RED_Y,
    ST_BLUE_X,
    ST_BLUE_Y,
    ST_DONE
  } orbit_state_t;

  localparam int         ANGLE_STEPS  = 60;
  localparam int         HALF_TURN    = 30;
  localparam int         QUARTER_TURN = 15;
  localparam logic [7:0] KEY_CCW      = 8'h04;
  localparam logic [7:0] KEY_CW       = 8'h07;
  localparam int         LUT_WIDTH    = 10;
  localparam int         LUT_FRAC     = 8;

  // round(256*sin(6 deg * k)) for the first quarter turn, k = 0..15
  function automatic logic signed [LUT_WIDTH-1:0] quarterSin(input logic [3:0] k);
    logic signed [LUT_WIDTH-1:0] value;
    case (k)
      4'd0:    value = 10'sd0;
      4'd1:    value = 10'sd27;
      4'd2:    value = 10'sd53;
      4'd3:    value = 10'sd79;
      4'd4:    value = 10'sd104;
      4'd5:    value = 10'sd128;
      4'd6:    value = 10'sd150;
      4'd7:    value = 10'sd171;
      4'd8:    value = 10'sd190;
      4'd9:    value = 10'sd207;
      4'd10:   value = 10'sd222;
      4'd11:   value = 10'sd234;
      4'd12:   value = 10'sd243;
      4'd13:   value = 10'sd250;
      4'd14:   value = 10'sd255;
      default: value = 10'sd256;
    endcase
    return value;
  endfunction

  // Full-circle sine by folding the index into the first quadrant.
  // Out-of-range indices (60..63) fall through to zero.
  function automatic logic signed [LUT_WIDTH-1:0] sinLookup(input logic [5:0] idx);
    logic signed [LUT_WIDTH-1:0] value;
    value = '0;
    if (idx <= 6'd15) begin
      value = quarterSin(idx[3:0]);
    end else if (idx <= 6'd30) begin
      value = quarterSin(4'(6'd30 - idx));
    end else if (idx <= 6'd45) begin
      value = -quarterSin(4'(idx - 6'd30));
    end else if (idx <= 6'd59) begin
      value = -quarterSin(4'(6'd60 - idx));
    end
    return value;
  endfunction

  // Cosine is the sine a quarter turn further round the circle
  function automatic logic signed [LUT_WIDTH-1:0] cosLookup(input logic [5:0] idx);
    logic [5:0] shifted;
    if (idx >= 6'(ANGLE_STEPS - QUARTER_TURN)) begin
      shifted = idx - 6'(ANGLE_STEPS - QUARTER_TURN);
    end else begin
      shifted = idx + 6'(QUARTER_TURN);
    end
    return sinLookup(shifted);
  endfunction

endpackage

// File: rtl/orbit_trig_lut.sv
// ---------------------------------------------------------------------------
// orbit_trig_lut
// Combinational 60-entry cos/sin ROM, 6 degrees per step, signed Q2.8.
// Ports:
//   i_index  6-bit angle step (0..59; 60..63 give zero)
//   o_cos    signed 10-bit round(256*cos)
//   o_sin    signed 10-bit round(256*sin)
// ---------------------------------------------------------------------------
module orbit_trig_lut
  import orbit_pkg::*;
(
  input  logic [5:0]                  i_index,
  output logic signed [LUT_WIDTH-1:0] o_cos,
  output logic signed [LUT_WIDTH-1:0] o_sin
);

  // Unused encodings above the last step read back as zero rather than
  // aliasing onto a real angle
  always_comb begin
    o_cos = '0;
    o_sin = '0;
    if (i_index < 6'(ANGLE_STEPS)) begin
      o_cos = cosLookup(i_index);
      o_sin = sinLookup(i_index);
    end
  end

endmodule

// File: rtl/orbit_ctrl.sv
// ---------------------------------------------------------------------------
// orbit_ctrl
// Moves a red and a blue ball around a circle, diametrically opposite each
// other. Once per frame the red angle steps according to the key, then the
// four coordinates are computed one per cycle through a single multiplier and
// published together.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_frameTick         one-cycle pulse per video frame
//   i_keycode           0x04 counter-clockwise, 0x07 clockwise
//   i_halt              freeze rotation (positions still recomputed)
//   o_redX/o_redY       red ball centre
//   o_blueX/o_blueY     blue ball centre
//   o_ballS             constant ball half-size
//   o_angleIndex        red angle step 0..59
//   o_posValid          one-cycle pulse when new positions are visible
//   o_busy              sequencer is not idle
// ---------------------------------------------------------------------------
module orbit_ctrl
  import orbit_pkg::*;
#(
  parameter int         CENTER_X  = 320,
  parameter int         CENTER_Y  = 240,
  parameter logic [7:0] RADIUS    = 8'd80,
  parameter int         BALL_SIZE = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_frameTick,
  input  logic [7:0] i_keycode,
  input  logic       i_halt,
  output logic [9:0] o_redX,
  output logic [9:0] o_redY,
  output logic [9:0] o_blueX,
  output logic [9:0] o_blueY,
  output logic [9:0] o_ballS,
  output logic [5:0] o_angleIndex,
  output logic       o_posValid,
  output logic       o_busy
);

  localparam logic [9:0] CENTER_X10   = 10'(CENTER_X);
  localparam logic [9:0] CENTER_Y10   = 10'(CENTER_Y);
  localparam logic [9:0] RESET_RED_X  = 10'(CENTER_X + int'(RADIUS));
  localparam logic [9:0] RESET_BLUE_X = 10'(CENTER_X - int'(RADIUS));
  localparam logic [5:0] LAST_STEP    = 6'(ANGLE_STEPS - 1);

  orbit_state_t r_state;
  logic         r_pending;
  logic [5:0]   r_angle;
  logic [9:0]   r_shadowRedX;
  logic [9:0]   r_shadowRedY;
  logic [9:0]   r_shadowBlueX;
  logic [9:0]   r_redX;
  logic [9:0]   r_redY;
  logic [9:0]   r_blueX;
  logic [9:0]   r_blueY;
  logic         r_posValid;
  logic         r_busy;

  logic [5:0]                  w_blueIndex;
  logic [5:0]                  w_lutIndex;
  logic                        w_isRed;
  logic                        w_isX;
  logic signed [LUT_WIDTH-1:0] w_cos;
  logic signed [LUT_WIDTH-1:0] w_sin;
  logic signed [LUT_WIDTH-1:0] w_trig;
  logic signed [17:0]          w_radiusExt;
  logic signed [17:0]          w_trigExt;
  logic signed [17:0]          w_product;
  logic [9:0]                  w_scaled;
  logic [9:0]                  w_coord;

  // The blue ball always sits half a turn away from the red one
  assign w_blueIndex = (r_angle >= 6'(HALF_TURN)) ? r_angle - 6'(HALF_TURN)
                                                  : r_angle + 6'(HALF_TURN);

  // The current computation state picks which ball and which axis the
  // shared multiplier works on this cycle
  assign w_isRed    = (r_state == ST_RED_X) || (r_state == ST_RED_Y);
  assign w_isX      = (r_state == ST_RED_X) || (r_state == ST_BLUE_X);
  assign w_lutIndex = w_isRed ? r_angle : w_blueIndex;

  orbit_trig_lut u_lut (
    .i_index (w_lutIndex),
    .o_cos   (w_cos),
    .o_sin   (w_sin)
  );

  assign w_trig = w_isX ? w_cos : w_sin;

  // Radius is unsigned, so it is zero-extended before the signed multiply;
  // the product of 255*256 still fits in 18 bits
  assign w_radiusExt = {10'd0, RADIUS};
  assign w_trigExt   = {{(18 - LUT_WIDTH){w_trig[LUT_WIDTH-1]}}, w_trig};
  assign w_product   = w_radiusExt * w_trigExt;
  assign w_scaled    = 10'(w_product >>> LUT_FRAC);

  // Screen Y grows downwards, hence the subtraction for the vertical axis
  assign w_coord = w_isX ? CENTER_X10 + w_scaled : CENTER_Y10 - w_scaled;

  // Sequencer: steps the angle, fills the shadow registers one coordinate per
  // cycle, then publishes all four positions on the edge into DONE so that
  // they are already visible while o_posValid is high. Ticks arriving while
  // busy collapse into a single pending request served right after DONE.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_pending     <= 1'b0;
      r_angle       <= '0;
      r_shadowRedX  <= RESET_RED_X;
      r_shadowRedY  <= CENTER_Y10;
      r_shadowBlueX <= RESET_BLUE_X;
      r_redX        <= RESET_RED_X;
      r_redY        <= CENTER_Y10;
      r_blueX       <= RESET_BLUE_X;
      r_blueY       <= CENTER_Y10;
      r_posValid    <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_posValid <= 1'b0;
      if (i_frameTick && (r_state != ST_IDLE)) begin
        r_pending <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_frameTick || r_pending) begin
            r_state   <= ST_STEP;
            r_pending <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        ST_STEP: begin
          if (!i_halt) begin
            if (i_keycode == KEY_CCW) begin
              r_angle <= (r_angle == LAST_STEP) ? 6'd0 : r_angle + 6'd1;
            end else if (i_keycode == KEY_CW) begin
              r_angle <= (r_angle == 6'd0) ? LAST_STEP : r_angle - 6'd1;
            end
          end
          r_state <= ST_RED_X;
        end
        ST_RED_X: begin
          r_shadowRedX <= w_coord;
          r_state      <= ST_RED_Y;
        end
        ST_RED_Y: begin
          r_shadowRedY <= w_coord;
          r_state      <= ST_BLUE_X;
        end
        ST_BLUE_X: begin
          r_shadowBlueX <= w_coord;
          r_state       <= ST_BLUE_Y;
        end
        ST_BLUE_Y: begin
          // The last coordinate goes straight to the output so that all
          // four change on the same edge
          r_redX     <= r_shadowRedX;
          r_redY     <= r_shadowRedY;
          r_blueX    <= r_shadowBlueX;
          r_blueY    <= w_coord;
          r_posValid <= 1'b1;
          r_state    <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_redX       = r_redX;
  assign o_redY       = r_redY;
  assign o_blueX      = r_blueX;
  assign o_blueY      = r_blueY;
  assign o_ballS      = 10'(BALL_SIZE);
  assign o_angleIndex = r_angle;
  assign o_posValid   = r_posValid;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_orbit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_orbit_ctrl
// Self-checking bench for orbit_ctrl. Table-driven key/halt vectors and a
// full-circle sweep feed a scoreboard of expected positions computed from a
// floating-point trig model; hand-written sequences cover latency, tick
// merging and reset in the middle of a sequence.
// ---------------------------------------------------------------------------
module tb_orbit_ctrl;

  logic       clock;
  logic       reset;
  logic       frameTick;
  logic [7:0] keycode;
  logic       halt;
  logic [9:0] redX;
  logic [9:0] redY;
  logic [9:0] blueX;
  logic [9:0] blueY;
  logic [9:0] ballS;
  logic [5:0] angleIndex;
  logic       posValid;
  logic       busy;

  typedef struct {
    int idx;
    int rx;
    int ry;
    int bx;
    int by;
  } expect_t;

  typedef struct {
    logic [7:0] key;
    logic       halt;
    int         expIdx;
  } vector_t;

  localparam int NV      = 13;
  localparam int LIT_ROW = 7;

  expect_t sb[$];
  vector_t vectors[NV];
  int      total      = 0;
  int      bad        = 0;
  int      pulseCount = 0;
  int      cur        = 0;

  orbit_ctrl dut (
    .i_clk        (clock),
    .i_reset      (reset),
    .i_frameTick  (frameTick),
    .i_keycode    (keycode),
    .i_halt       (halt),
    .o_redX       (redX),
    .o_redY       (redY),
    .o_blueX      (blueX),
    .o_blueY      (blueY),
    .o_ballS      (ballS),
    .o_angleIndex (angleIndex),
    .o_posValid   (posValid),
    .o_busy       (busy)
  );

  // Free-running 100 MHz clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case a wait loop misbehaves
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int modelTrig(int idx, bit isSin);
    real ang;
    real v;
    ang = 6.0 * real'(idx) * 3.14159265358979 / 180.0;
    v   = 256.0 * (isSin ? $sin(ang) : $cos(ang));
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  function automatic int modelCoord(int idx, bit isX, bit isBlue);
    int i;
    int t;
    int s;
    i = isBlue ? (idx + 30) % 60 : idx;
    t = modelTrig(i, !isX);
    s = $rtoi($floor(real'(80 * t) / 256.0));
    return isX ? ((320 + s) & 1023) : ((240 - s) & 1023);
  endfunction

  function automatic expect_t makeExpect(int idx);
    expect_t e;
    e.idx = idx;
    e.rx  = modelCoord(idx, 1'b1, 1'b0);
    e.ry  = modelCoord(idx, 1'b0, 1'b0);
    e.bx  = modelCoord(idx, 1'b1, 1'b1);
    e.by  = modelCoord(idx, 1'b0, 1'b1);
    return e;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard consumer: every o_posValid pulse must match the oldest
  // expected position set
  always @(negedge clock) begin
    expect_t e;
    if (!reset && posValid) begin
      pulseCount++;
      if (sb.size() == 0) begin
        checkOutput("unexpectedPosValid", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("angleIndex", int'(angleIndex), e.idx);
        checkOutput("redX", int'(redX), e.rx);
        checkOutput("redY", int'(redY), e.ry);
        checkOutput("blueX", int'(blueX), e.bx);
        checkOutput("blueY", int'(blueY), e.by);
      end
    end
  end

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clock);
    while (busy && n < 30) begin
      @(negedge clock);
      n++;
    end
    if (busy) checkOutput("idleTimeout", int'(busy), 0);
  endtask

  task automatic applyStimulus(input logic [7:0] key, input logic h, input int expIdx);
    int startPulses;
    int waited;
    waitIdle();
    @(negedge clock);
    keycode   = key;
    halt      = h;
    frameTick = 1'b1;
    sb.push_back(makeExpect(expIdx));
    startPulses = pulseCount;
    @(negedge clock);
    frameTick = 1'b0;
    waited = 0;
    while (pulseCount == startPulses && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    checkOutput("pulseSeen", int'(pulseCount > startPulses), 1);
  endtask

  initial begin
    int latency;
    int prevRx;
    int p1;
    int p2;
    int pulses;
    expect_t e;

    // Stimulus table: key, halt, expected red angle step afterwards
    vectors[0]  = '{8'h00, 1'b0, 0};
    vectors[1]  = '{8'h07, 1'b0, 59};
    vectors[2]  = '{8'h04, 1'b0, 0};
    vectors[3]  = '{8'h04, 1'b0, 1};
    vectors[4]  = '{8'h04, 1'b0, 2};
    vectors[5]  = '{8'h04, 1'b0, 3};
    vectors[6]  = '{8'h04, 1'b0, 4};
    vectors[7]  = '{8'h04, 1'b0, 5};
    vectors[8]  = '{8'h04, 1'b1, 5};
    vectors[9]  = '{8'h07, 1'b1, 5};
    vectors[10] = '{8'h07, 1'b0, 4};
    vectors[11] = '{8'h05, 1'b0, 4};
    vectors[12] = '{8'h06, 1'b0, 4};

    reset     = 1'b1;
    frameTick = 1'b0;
    keycode   = 8'h00;
    halt      = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("resetIndex", int'(angleIndex), 0);
    checkOutput("resetPosValid", int'(posValid), 0);
    checkOutput("resetBusy", int'(busy), 0);
    checkOutput("resetRedX", int'(redX), 400);
    checkOutput("resetRedY", int'(redY), 240);
    checkOutput("resetBlueX", int'(blueX), 240);
    checkOutput("resetBlueY", int'(blueY), 240);
    checkOutput("ballS", int'(ballS), 4);
    reset = 1'b0;

    $display("[TB] table vectors");
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vectors[i].key, vectors[i].halt, vectors[i].expIdx);
      cur = vectors[i].expIdx;
      if (i == LIT_ROW) begin
        checkOutput("litRedX", int'(redX), 389);
        checkOutput("litRedY", int'(redY), 200);
        checkOutput("litBlueX", int'(blueX), 250);
        checkOutput("litBlueY", int'(blueY), 280);
      end
    end

    $display("[TB] full circle sweep");
    for (int i = 0; i < 58; i++) begin
      cur = (cur + 1) % 60;
      applyStimulus(8'h04, 1'b0, cur);
    end

    // Latency and no mid-sequence update; key/halt change after STEP
    $display("[TB] latency sequence");
    waitIdle();
    prevRx = modelCoord(cur, 1'b1, 1'b0);
    @(negedge clock);
    keycode   = 8'h04;
    halt      = 1'b0;
    frameTick = 1'b1;
    cur = (cur + 1) % 60;
    sb.push_back(makeExpect(cur));
    latency = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock);
      #1;
      if (k == 1) frameTick = 1'b0;
      if (k == 2) begin
        keycode = 8'h07;
        halt    = 1'b1;
      end
      if (posValid && latency < 0) latency = k;
      if (latency < 0) checkOutput("holdRedX", int'(redX), prevRx);
    end
    checkOutput("latency", latency, 6);
    keycode = 8'h00;
    halt    = 1'b0;

    // Two extra ticks while busy merge into one more sequence
    $display("[TB] tick merge sequence");
    waitIdle();
    @(negedge clock);
    frameTick = 1'b1;
    e = makeExpect(cur);
    sb.push_back(e);
    sb.push_back(e);
    p1 = -1;
    p2 = -1;
    pulses = 0;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clock);
      #1;
      frameTick = (k == 2) || (k == 4);
      if (posValid) begin
        pulses++;
        if (p1 < 0) p1 = k;
        else if (p2 < 0) p2 = k;
      end
    end
    frameTick = 1'b0;
    checkOutput("mergePulses", pulses, 2);
    checkOutput("mergeFirst", p1, 6);
    checkOutput("mergeGap", p2 - p1, 7);

    // Reset while computing RED_Y aborts without a pulse
    $display("[TB] reset mid-sequence");
    waitIdle();
    @(negedge clock);
    keycode   = 8'h04;
    frameTick = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clock);
      #1;
      if (k == 1) frameTick = 1'b0;
    end
    checkOutput("busyInRedY", int'(busy), 1);
    reset     = 1'b1;
    frameTick = 1'b1;
    @(posedge clock);
    #1;
    reset     = 1'b0;
    frameTick = 1'b0;
    keycode   = 8'h00;
    checkOutput("abortBusy", int'(busy), 0);
    checkOutput("abortPosValid", int'(posValid), 0);
    checkOutput("abortIndex", int'(angleIndex), 0);
    checkOutput("abortRedX", int'(redX), 400);
    checkOutput("abortRedY", int'(redY), 240);
    checkOutput("abortBlueX", int'(blueX), 240);
    checkOutput("abortBlueY", int'(blueY), 240);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clock);
      #1;
      if (posValid) pulses++;
    end
    checkOutput("abortNoPulse", pulses, 0);
    checkOutput("scoreboardDrained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
